// File: rtl/block_scale_detector.sv
// Block-exponent detector: tracks the widest sample in a frame of FRAME_LEN
// valid samples and, at frame end, publishes the largest left-shift at which
// every sample still fits the downstream shifter's OUT_WIDTH window.
module block_scale_detector #(
  parameter  int IN_WIDTH   = 20,
  parameter  int SHFT_WIDTH = 4,
  parameter  int OUT_WIDTH  = 8,
  parameter  int FRAME_LEN  = 16,
  parameter  int MAX_SHIFT  = IN_WIDTH - OUT_WIDTH,
  localparam int CNT_WIDTH  = $clog2(FRAME_LEN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        frame_clear,
  output logic [SHFT_WIDTH-1:0]       shift,
  output logic                        shift_valid,
  output logic [CNT_WIDTH-1:0]        sample_idx
);

  localparam int LZ_W = SHFT_WIDTH + 1;

  // Leading-zero count over the IN_WIDTH-1 magnitude bits; all-zero gives IN_WIDTH-1.
  function automatic logic [LZ_W-1:0] count_lz(input logic [IN_WIDTH-2:0] v);
    logic [LZ_W-1:0] n;
    n = LZ_W'(IN_WIDTH - 1);
    for (int i = 0; i < IN_WIDTH - 1; i++) begin
      if (v[i]) n = LZ_W'(IN_WIDTH - 2 - i);
    end
    return n;
  endfunction

  // Saturate the raw count so the shifter window never runs off the bottom of the word.
  function automatic logic [SHFT_WIDTH-1:0] sat_shift(input logic [LZ_W-1:0] lz);
    if (lz > LZ_W'(MAX_SHIFT)) return SHFT_WIDTH'(MAX_SHIFT);
    return lz[SHFT_WIDTH-1:0];
  endfunction

  logic [IN_WIDTH-2:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  idx_q, idx_d;
  logic [SHFT_WIDTH-1:0] shift_q, shift_d;
  logic                  shift_valid_q, shift_valid_d;

  logic [IN_WIDTH-2:0]   norm;
  logic [IN_WIDTH-2:0]   final_or;
  logic                  last_sample;

  // Sign-fold each sample so redundant sign bits become leading zeros.
  assign norm        = in_data[IN_WIDTH-2:0] ^ {(IN_WIDTH-1){in_data[IN_WIDTH-1]}};
  assign final_or    = acc_q | norm;
  assign last_sample = (idx_q == CNT_WIDTH'(FRAME_LEN - 1));

  // Next-state: clear beats a sample; the frame-end sample folds in combinationally.
  always_comb begin
    acc_d         = acc_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    shift_valid_d = 1'b0;
    if (frame_clear) begin
      acc_d = '0;
      idx_d = '0;
    end else if (in_valid) begin
      if (last_sample) begin
        shift_d       = sat_shift(count_lz(final_or));
        shift_valid_d = 1'b1;
        acc_d         = '0;
        idx_d         = '0;
      end else begin
        acc_d = final_or;
        idx_d = idx_q + CNT_WIDTH'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      shift_valid_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      shift_valid_q <= shift_valid_d;
    end
  end

  assign shift       = shift_q;
  assign shift_valid = shift_valid_q;
  assign sample_idx  = idx_q;

endmodule
